// File: rtl/srdl2sv_if_pkg.sv
// Shared register-block interface types for srdl2sv bus frontends.
//   b2r_t       : bus-to-register request (w_vld, r_vld, addr, data, byte_en)
//   r2b_t       : register-to-bus response (rdy, err, data)
//   arb_state_e : access-port scheduler state, shared by arbiters/schedulers
package srdl2sv_if_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;

  typedef struct packed {
    logic              w_vld;
    logic              r_vld;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   byte_en;
  } b2r_t;

  typedef struct packed {
    logic              rdy;
    logic              err;
    logic [DATA_W-1:0] data;
  } r2b_t;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/srdl2sv_b2r_arbiter_rr.sv
// Purely combinational round-robin picker.
//   i_pending     : one bit per requester, set when it wants the port
//   i_last        : index of the most recently served requester
//   o_pick        : first pending index searching from i_last+1 with wrap
//   o_any_pending : at least one requester is pending
module srdl2sv_rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_pending,
  input  logic [IDX_W-1:0]   i_last,
  output logic [IDX_W-1:0]   o_pick,
  output logic               o_any_pending
);

  int unsigned w_idx;

  always_comb begin
    o_pick        = '0;
    o_any_pending = 1'b0;
    w_idx         = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_idx = (32'(i_last) + k) % NUM_REQ;
      if (!o_any_pending && i_pending[IDX_W'(w_idx)]) begin
        o_any_pending = 1'b1;
        o_pick        = IDX_W'(w_idx);
      end
    end
  end

endmodule

// File: rtl/srdl2sv_b2r_arbiter.sv
// Shares one register-block access port between NUM_REQ bus frontends.
// Round-robin arbitration, grant held for one complete access, response
// routed only to the granted frontend, optional timeout -> error response.
//   HCLK, HRESETn : clock, asynchronous active-low reset
//   req_b2r       : per-frontend requests
//   req_r2b       : per-frontend responses (zero for non-granted frontends)
//   reg_b2r       : request forwarded to the register block
//   reg_r2b       : response from the register block
//   gnt_idx       : current/last granted frontend
module srdl2sv_b2r_arbiter
  import srdl2sv_if_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                       HCLK,
  input  logic                       HRESETn,
  input  b2r_t                       req_b2r [NUM_REQ],
  output r2b_t                       req_r2b [NUM_REQ],
  output b2r_t                       reg_b2r,
  input  r2b_t                       reg_r2b,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  arb_state_e       r_state, w_state_nxt;
  logic [IDX_W-1:0] r_last, w_last_nxt;
  logic [IDX_W-1:0] r_gnt_idx, w_gnt_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [NUM_REQ-1:0] w_pending;
  logic [IDX_W-1:0] w_pick;
  logic             w_any;
  logic             w_release;
  b2r_t             w_gnt_req;
  r2b_t             w_resp;
  r2b_t             w_err_resp;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_pending[i] = req_b2r[i].w_vld | req_b2r[i].r_vld;
    end
  end

  srdl2sv_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .i_pending     (w_pending),
    .i_last        (r_last),
    .o_pick        (w_pick),
    .o_any_pending (w_any)
  );

  assign w_gnt_req  = req_b2r[r_gnt_idx];
  assign w_err_resp = '{rdy: 1'b1, err: 1'b1, data: '0};

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state   <= ARB_IDLE;
      r_last    <= IDX_W'(NUM_REQ - 1);
      r_gnt_idx <= '0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_last    <= w_last_nxt;
      r_gnt_idx <= w_gnt_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_gnt_nxt   = r_gnt_idx;
    w_cnt_nxt   = r_cnt;
    w_release   = 1'b0;
    reg_b2r     = '0;
    w_resp      = '0;

    unique case (r_state)
      ARB_IDLE: begin
        if (w_any) begin
          w_gnt_nxt   = w_pick;
          w_state_nxt = ARB_GRANT;
          w_cnt_nxt   = '0;
        end
      end
      ARB_GRANT: begin
        if (!(w_gnt_req.w_vld || w_gnt_req.r_vld)) begin
          // Requester withdrew: free the port silently.
          w_release = 1'b1;
        end else if (w_gnt_req.w_vld && w_gnt_req.r_vld) begin
          w_resp    = w_err_resp;
          w_release = 1'b1;
        end else begin
          reg_b2r = w_gnt_req;
          w_resp  = reg_r2b;
          if (reg_r2b.rdy) begin
            w_release = 1'b1;
          end else if (TIMEOUT_CYCLES > 0 && r_cnt == CNT_LAST) begin
            // Abort the hung access; the register block never sees vld again.
            reg_b2r.w_vld = 1'b0;
            reg_b2r.r_vld = 1'b0;
            w_resp        = w_err_resp;
            w_release     = 1'b1;
          end else if (r_cnt != '1) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        if (w_release) begin
          w_state_nxt = ARB_IDLE;
          w_last_nxt  = r_gnt_idx;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_r2b[i] = (r_gnt_idx == IDX_W'(i)) ? w_resp : '0;
    end
  end

  assign gnt_idx = r_gnt_idx;

endmodule

// File: tb/tb_srdl2sv_b2r_arbiter.sv
module tb_srdl2sv_b2r_arbiter;
  import srdl2sv_if_pkg::*;

  localparam int NREQ = 3;
  localparam int TMO  = 4;

  logic       HCLK = 1'b0;
  logic       HRESETn;
  b2r_t       req_b2r [NREQ];
  r2b_t       req_r2b [NREQ];
  b2r_t       reg_b2r;
  r2b_t       reg_r2b;
  logic [1:0] gnt_idx;

  srdl2sv_b2r_arbiter #(.NUM_REQ(NREQ), .TIMEOUT_CYCLES(TMO)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .req_b2r (req_b2r),
    .req_r2b (req_r2b),
    .reg_b2r (reg_b2r),
    .reg_r2b (reg_r2b),
    .gnt_idx (gnt_idx)
  );

  always #5 HCLK = ~HCLK;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Frontend stimulus knobs and state
  int p_issue [NREQ];
  int kind    [NREQ];   // 0 random, 1 read, 2 illegal w+r, 3 write to 0x10
  int drop_pct = 0;
  int lat_mode = 0;     // >=0 fixed latency, -1 random incl. hang, -2 random short
  bit fe_act  [NREQ];
  bit fe_done [NREQ];

  // Register block responder
  bit rb_act = 0;
  int rb_n, rb_lat;

  // Reference model: who owns the port and for how long
  bit m_busy;
  int m_owner, m_last, m_gnt, m_age;
  int cyc = 0;
  int done_log[$];
  int done_cyc[$];

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_last = NREQ - 1; m_gnt = 0; m_age = 0; rb_act = 0;
  endtask

  task automatic fe_update();
    b2r_t t;
    int   r;
    for (int i = 0; i < NREQ; i++) begin
      if (fe_act[i] && fe_done[i]) begin
        fe_act[i] = 0; req_b2r[i] = '0;
      end else if (fe_act[i] && $urandom_range(99) < drop_pct) begin
        fe_act[i] = 0; req_b2r[i] = '0;
      end
      fe_done[i] = 0;
      if (!fe_act[i] && $urandom_range(99) < p_issue[i]) begin
        t = '0;
        t.addr = $urandom; t.data = $urandom; t.byte_en = 4'($urandom);
        r = $urandom_range(99);
        case (kind[i])
          1: t.r_vld = 1'b1;
          2: begin t.w_vld = 1'b1; t.r_vld = 1'b1; end
          3: begin t.w_vld = 1'b1; t.addr = 32'h10; end
          default: begin
            if (r < 8) begin t.w_vld = 1'b1; t.r_vld = 1'b1; end
            else if (r < 54) t.w_vld = 1'b1;
            else t.r_vld = 1'b1;
          end
        endcase
        req_b2r[i] = t; fe_act[i] = 1;
      end
    end
  endtask

  task automatic model_check();
    r2b_t exp_r [NREQ];
    r2b_t err_r;
    b2r_t g;
    bit   fwd, rel;
    fwd = 0; rel = 0; g = '0;
    err_r = '0; err_r.rdy = 1'b1; err_r.err = 1'b1;
    for (int i = 0; i < NREQ; i++) exp_r[i] = '0;
    check("gnt_idx", 80'(gnt_idx), 80'(m_gnt));
    if (m_busy) begin
      m_age++;
      g = req_b2r[m_owner];
      if (!g.w_vld && !g.r_vld) rel = 1;
      else if (g.w_vld && g.r_vld) begin exp_r[m_owner] = err_r; rel = 1; end
      else if (reg_r2b.rdy) begin fwd = 1; exp_r[m_owner] = reg_r2b; rel = 1; end
      else if (m_age == TMO) begin exp_r[m_owner] = err_r; rel = 1; end
      else begin fwd = 1; exp_r[m_owner] = reg_r2b; end
    end
    check("reg_vld", 80'({reg_b2r.w_vld, reg_b2r.r_vld}), fwd ? 80'({g.w_vld, g.r_vld}) : 80'(0));
    if (fwd) check("reg_b2r", 80'(reg_b2r), 80'(g));
    for (int i = 0; i < NREQ; i++) begin
      check($sformatf("req_r2b%0d", i), 80'(req_r2b[i]), 80'(exp_r[i]));
      if (req_r2b[i].rdy) begin
        fe_done[i] = 1; done_log.push_back(i); done_cyc.push_back(cyc);
      end
    end
    if (rel) begin
      m_busy = 0; m_last = m_owner; rb_act = 0;
    end else if (!m_busy) begin
      for (int k = 1; k <= NREQ; k++) begin
        int c;
        c = (m_last + k) % NREQ;
        if (!m_busy && (req_b2r[c].w_vld || req_b2r[c].r_vld)) begin
          m_busy = 1; m_owner = c; m_gnt = c; m_age = 0;
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge HCLK); #1;
    fe_update();
    reg_r2b = '0;
    reg_r2b.err  = 1'($urandom_range(1));
    reg_r2b.data = $urandom;
    #1;
    if (!rb_act && (reg_b2r.w_vld || reg_b2r.r_vld)) begin
      rb_act = 1; rb_n = 0;
      if (lat_mode >= 0) rb_lat = lat_mode;
      else if (lat_mode == -2) rb_lat = $urandom_range(2);
      else rb_lat = ($urandom_range(99) < 20) ? 9 : $urandom_range(4);
    end
    if (rb_act) begin
      if (rb_n == rb_lat) reg_r2b.rdy = 1'b1;
      rb_n++;
    end
    @(negedge HCLK);
    model_check();
    cyc++;
  endtask

  task automatic drain();
    bit busy;
    for (int i = 0; i < NREQ; i++) p_issue[i] = 0;
    drop_pct = 0;
    for (int n = 0; n < 100; n++) begin
      busy = m_busy;
      for (int i = 0; i < NREQ; i++) busy |= fe_act[i];
      if (!busy) break;
      cycle();
    end
    busy = m_busy;
    for (int i = 0; i < NREQ; i++) busy |= fe_act[i];
    check("drain", 80'(busy), 80'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no_finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    r2b_t err_r;
    bit   ok;
    err_r = '0; err_r.rdy = 1'b1; err_r.err = 1'b1;
    HRESETn = 1'b0;
    reg_r2b = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_b2r[i] = '0; req_r2b[i] = '0; p_issue[i] = 0; kind[i] = 0; fe_act[i] = 0; fe_done[i] = 0;
    end
    model_reset();
    #3;
    check("rst_gnt", 80'(gnt_idx), 80'(0));
    check("rst_vld", 80'({reg_b2r.w_vld, reg_b2r.r_vld}), 80'(0));
    for (int i = 0; i < NREQ; i++)
      check($sformatf("rst_rdy%0d", i), 80'({req_r2b[i].rdy, req_r2b[i].err}), 80'(0));
    #9 HRESETn = 1'b1;

    // Single requester: write 0x10, register ready after 2 cycles
    lat_mode = 2; kind[0] = 3; p_issue[0] = 100;
    cycle();
    p_issue[0] = 0;
    cycle();
    check("single_wvld", 80'(reg_b2r.w_vld), 80'(1));
    check("single_addr", 80'(reg_b2r.addr), 80'(32'h10));
    cycle();
    check("single_rdy_c2", 80'(req_r2b[0].rdy), 80'(0));
    cycle();
    check("single_rdy_c3", 80'(req_r2b[0].rdy), 80'(1));
    check("single_other", 80'(req_r2b[1]), 80'(0));
    drain();

    // Illegal w_vld+r_vld: error in first grant cycle, nothing forwarded
    kind[0] = 2; p_issue[0] = 100;
    cycle();
    p_issue[0] = 0;
    cycle();
    check("illegal_vld", 80'({reg_b2r.w_vld, reg_b2r.r_vld}), 80'(0));
    check("illegal_resp", 80'(req_r2b[0]), 80'(err_r));
    drain();

    // Timeout: register block hangs, error in 4th grant cycle, next served
    lat_mode = 9; kind[1] = 1; kind[2] = 1; p_issue[1] = 100;
    cycle();
    p_issue[1] = 0; p_issue[2] = 100;
    cycle();
    p_issue[2] = 0;
    cycle();
    cycle();
    cycle();
    check("tmo_resp", 80'(req_r2b[1]), 80'(err_r));
    cycle();
    check("tmo_idle_gnt", 80'(gnt_idx), 80'(1));
    check("tmo_idle_vld", 80'({reg_b2r.w_vld, reg_b2r.r_vld}), 80'(0));
    cycle();
    check("tmo_next_gnt", 80'(gnt_idx), 80'(2));
    check("tmo_next_rvld", 80'(reg_b2r.r_vld), 80'(1));
    drain();

    // Asynchronous reset in the middle of a hung grant
    lat_mode = 9;
    for (int i = 0; i < NREQ; i++) begin kind[i] = 1; p_issue[i] = 100; end
    for (int n = 0; n < 40; n++) begin
      if (m_busy && m_age >= 2) break;
      cycle();
    end
    check("reach_grant", 80'(m_busy), 80'(1));
    #2 HRESETn = 1'b0;
    #1;
    check("arst_vld", 80'({reg_b2r.w_vld, reg_b2r.r_vld}), 80'(0));
    check("arst_gnt", 80'(gnt_idx), 80'(0));
    for (int i = 0; i < NREQ; i++)
      check($sformatf("arst_rdy%0d", i), 80'({req_r2b[i].rdy, req_r2b[i].err}), 80'(0));

    // Contention after reset: all read, immediate ready -> 0,1,2,0
    model_reset();
    lat_mode = 0;
    for (int i = 0; i < NREQ; i++) begin
      req_b2r[i] = '0; req_b2r[i].r_vld = 1'b1; req_b2r[i].addr = $urandom;
      fe_act[i] = 1; fe_done[i] = 0;
    end
    done_log.delete(); done_cyc.delete();
    @(negedge HCLK); #1 HRESETn = 1'b1;
    #1 model_check();
    cyc++;
    repeat (8) cycle();
    check("ctn_count", 80'(done_log.size() >= 4), 80'(1));
    if (done_log.size() >= 4) begin
      check("ctn_ord0", 80'(done_log[0]), 80'(0));
      check("ctn_ord1", 80'(done_log[1]), 80'(1));
      check("ctn_ord2", 80'(done_log[2]), 80'(2));
      check("ctn_ord3", 80'(done_log[3]), 80'(0));
      for (int k = 0; k < 3; k++)
        check("ctn_gap", 80'(done_cyc[k+1] - done_cyc[k]), 80'(2));
    end

    // Fairness: requesters 0 and 1 always pending
    p_issue[2] = 0; lat_mode = -2;
    repeat (10) cycle();
    done_log.delete(); done_cyc.delete();
    repeat (40) cycle();
    check("fair_count", 80'(done_log.size() >= 8), 80'(1));
    ok = 1;
    for (int k = 0; k + 1 < done_log.size(); k++)
      if (done_log[k] == done_log[k+1] || done_log[k] > 1) ok = 0;
    check("fair_alternate", 80'(ok), 80'(1));
    drain();

    // Randomized traffic
    for (int i = 0; i < NREQ; i++) begin kind[i] = 0; p_issue[i] = 30; end
    drop_pct = 2; lat_mode = -1;
    repeat (3000) cycle();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/srdl2sv_b2r_arbiter.md
Name: srdl2sv_b2r_arbiter

Overview:
- Shares one register-block access port (b2r/r2b, from srdl2sv_if_pkg) between NUM_REQ bus-protocol frontends, e.g. an AHB-Lite slave plus a debug or APB frontend.
- Round-robin arbitration; a grant is held for one complete register access.
- The register block's response is routed back to the granted frontend only.
- Optional timeout converts a hung register access into an error response.

Parameters:
- NUM_REQ, 2, number of requesting frontends (2..8).
- TIMEOUT_CYCLES, 0, maximum cycles in GRANT before a forced error response; 0 disables the timeout.

Ports:
- HCLK  input  1  clock
- HRESETn  input  1  reset, asynchronous, active-low
- req_b2r  input  b2r_t[NUM_REQ]  per-frontend request (w_vld, r_vld, addr, data, byte_en)
- req_r2b  output  r2b_t[NUM_REQ]  per-frontend response (rdy, err, data)
- reg_b2r  output  b2r_t  request forwarded to register block
- reg_r2b  input  r2b_t  response from register block
- gnt_idx  output  $clog2(NUM_REQ)  index of current/last grant, for debug

Behaviour:
- Reset is HRESETn, asynchronous, active-low, on clock HCLK. On reset:
  - state = IDLE; last pointer = NUM_REQ-1, so requester 0 wins first; gnt_idx = 0; timeout counter = 0.
  - reg_b2r.w_vld/r_vld = 0; all req_r2b.rdy/err = 0.
- A requester is pending when w_vld | r_vld.
- A requester holds its request stable until it sees its own rdy. Non-granted requesters always see rdy = 0, err = 0, data = 0.
- State IDLE:
  - reg_b2r vld bits = 0.
  - If any pending: round-robin pick, searching from last+1 with wrap-around.
  - Next edge: gnt_idx <= pick, state <= GRANT, counter <= 0.
  - Arbitration latency is 1 cycle from request to forward.
- State GRANT:
  - reg_b2r = req_b2r[gnt_idx], combinationally. req_r2b[gnt_idx] = reg_r2b, combinationally.
  - reg_r2b.rdy = 1: access completes that cycle; next edge last <= gnt_idx, state <= IDLE.
  - Consequence: minimum one idle cycle between grants, so at most one access per 2 cycles.
  - Both w_vld and r_vld set by the granted requester: reg_b2r vld bits forced to 0; req_r2b[gnt_idx] = {rdy=1, err=1} in that cycle; then release as above.
  - Granted requester drops both vld bits (protocol violation): forward 0; release at next edge with no response; last <= gnt_idx.
  - Timeout (TIMEOUT_CYCLES > 0):
    - Counter increments each GRANT cycle without rdy.
    - When counter == TIMEOUT_CYCLES-1 and rdy = 0: drive req_r2b[gnt_idx] = {rdy=1, err=1, data=0}, keep reg_b2r vld = 0 that cycle, and release.
    - Counter width is $clog2(TIMEOUT_CYCLES+1) and it saturates.
    - rdy and timeout in the same cycle: the real response wins.
- Reset mid-GRANT: outputs return to reset values immediately (asynchronous). The outstanding access is abandoned; frontends re-issue after reset.
- gnt_idx holds its value in IDLE.

Decomposition:
- b2r_t and r2b_t are already in srdl2sv_if_pkg.
- Add the arbiter state enum (ARB_IDLE, ARB_GRANT) to srdl2sv_if_pkg for reuse by future schedulers.
- Sub-module srdl2sv_rr_arbiter:
  - Purely combinational round-robin picker.
  - Inputs: pending vector, last pointer. Outputs: pick index, any_pending.
  - Reusable and unit-testable on its own.

Test Plan:
- Single requester: req 0 write addr 0x10, reg rdy after 2 cycles -> reg_b2r.w_vld visible from cycle 1; req_r2b[0].rdy=1 in cycle 3; req_r2b[1] stays 0.
- Contention, NUM_REQ=3: all three read simultaneously, reg rdy immediate -> grant order 0,1,2,0; each grant separated by one IDLE cycle.
- Fairness: req 0 continuously pending, req 1 pending -> grants alternate 0,1,0,1; req 1 never starved.
- Timeout, TIMEOUT_CYCLES=4: reg rdy never asserted -> req_r2b[gnt].rdy=1, err=1 in the 4th GRANT cycle; arbiter returns to IDLE; next requester served.
- Illegal request: granted requester sets w_vld=r_vld=1 -> no vld forwarded; error response in the first GRANT cycle.
- Asynchronous reset asserted mid-GRANT -> reg_b2r vld bits and all rdy drop immediately; after release, requester 0 has priority.
